// File: rtl/simon_game_ctrl_if.sv
// simon_game_ctrl_if - player/display side signals of the Simon game sequencer.
//   start : one-cycle pulse, begins a new game (driven by master)
//   btn   : one-cycle press pulses, bit i is colour i (driven by master)
//   led   : one-hot colour being shown, 0 when dark (driven by slave)
//   value : score in BCD, [3:0] units, [7:4] tens (driven by slave)
//   lose  : game lost, held until the next accepted start (driven by slave)
//   win   : game won, held until the next accepted start (driven by slave)
//   busy  : sequencer not in IDLE (driven by slave)
interface simon_game_ctrl_if;
    logic        start;
    logic [3:0]  btn;
    logic [3:0]  led;
    logic [31:0] value;
    logic        lose;
    logic        win;
    logic        busy;

    modport master (output start, btn, input led, value, lose, win, busy);
    modport slave  (input start, btn, output led, value, lose, win, busy);
endinterface

// File: rtl/simon_game_ctrl.sv
// simon_game_ctrl - Simon game sequencer. Grows a pseudo-random colour sequence
// by one step per round, plays it on four LEDs, checks button presses against
// it and keeps a BCD score.
//   CLK        : system clock
//   CPU_RESETN : asynchronous active-low reset
//   bus        : slave side of simon_game_ctrl_if (start/btn in, led/value/
//                lose/win/busy out, all outputs registered)
module simon_game_ctrl #(
    parameter int          TICKS_PER_STEP = 50_000_000,
    parameter int          TIMEOUT_STEPS  = 10,
    parameter int          MAX_LEN        = 32,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic            CLK,
    input  logic            CPU_RESETN,
    simon_game_ctrl_if.slave bus
);

    localparam int TMAX = TICKS_PER_STEP * TIMEOUT_STEPS;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] STEP_LAST = TW'(TICKS_PER_STEP - 1);
    // Last cycle of the input window: a press here still wins over the timeout.
    localparam logic [TW-1:0] TO_LAST   = TW'(TMAX - 1);
    localparam logic [5:0]    LEN_MAX   = 6'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_ADD, S_SHOW_ON, S_SHOW_OFF, S_INPUT, S_LOSE, S_WIN
    } state_t;

    state_t           state;
    logic [15:0]      lfsr;
    logic [31:0][1:0] seq;
    logic [5:0]       len;
    logic [4:0]       idx;
    logic [TW-1:0]    timer;
    logic [3:0]       units, tens;
    logic [3:0]       led_q;
    logic             lose_q, win_q, busy_q;

    logic             fb;
    logic             idx_last;
    logic [3:0]       cur_oh;

    function automatic logic [3:0] onehot(input logic [1:0] c);
        onehot = 4'b0001 << c;
    endfunction

    assign fb       = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign idx_last = ({1'b0, idx} == len - 6'd1);
    assign cur_oh   = onehot(seq[idx]);

    assign bus.led   = led_q;
    assign bus.value = {24'd0, tens, units};
    assign bus.lose  = lose_q;
    assign bus.win   = win_q;
    assign bus.busy  = busy_q;

    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state  <= S_IDLE;
            lfsr   <= LFSR_SEED;
            seq    <= '0;
            len    <= '0;
            idx    <= '0;
            timer  <= '0;
            units  <= '0;
            tens   <= '0;
            led_q  <= '0;
            lose_q <= 1'b0;
            win_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            lfsr <= {lfsr[14:0], fb};
            // LED trails the state by one cycle so each phase is exactly
            // TICKS_PER_STEP cycles and the colour reads a settled seq entry.
            led_q <= (state == S_SHOW_ON) ? cur_oh : 4'd0;

            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        len    <= '0;
                        units  <= '0;
                        tens   <= '0;
                        lose_q <= 1'b0;
                        win_q  <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= S_ADD;
                    end
                end
                S_ADD: begin
                    seq[len[4:0]] <= lfsr[1:0];
                    len   <= len + 6'd1;
                    idx   <= '0;
                    timer <= '0;
                    state <= S_SHOW_ON;
                end
                S_SHOW_ON: begin
                    if (timer == STEP_LAST) begin
                        timer <= '0;
                        state <= S_SHOW_OFF;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_SHOW_OFF: begin
                    if (timer == STEP_LAST) begin
                        timer <= '0;
                        if (idx_last) begin
                            idx   <= '0;
                            state <= S_INPUT;
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= S_SHOW_ON;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_INPUT: begin
                    if (bus.btn != 4'd0) begin
                        if (bus.btn == cur_oh) begin
                            if (idx_last) begin
                                if (units == 4'd9) begin
                                    units <= 4'd0;
                                    tens  <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
                                end else begin
                                    units <= units + 4'd1;
                                end
                                state <= (len == LEN_MAX) ? S_WIN : S_ADD;
                            end else begin
                                idx   <= idx + 5'd1;
                                timer <= '0;
                            end
                        end else begin
                            // Includes multi-bit presses, which never match a one-hot.
                            state <= S_LOSE;
                        end
                    end else if (timer == TO_LAST) begin
                        state <= S_LOSE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_LOSE: begin
                    lose_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                S_WIN: begin
                    win_q  <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_game_ctrl.sv
// tb_simon_game_ctrl - self-checking bench for simon_game_ctrl with
// TICKS_PER_STEP=4, TIMEOUT_STEPS=3, MAX_LEN=4. Game scenarios come from a
// vector table; the shown sequence is kept in a scoreboard queue and replayed.
module tb_simon_game_ctrl;

    localparam int T = 4;
    localparam int S = 3;
    localparam int M = 4;

    localparam int A_NONE    = 0;
    localparam int A_OK      = 1;
    localparam int A_WRONG   = 2;
    localparam int A_TIMEOUT = 3;
    localparam int A_MULTI   = 4;

    typedef struct {
        int          rounds_ok;  // rounds echoed correctly
        int          wait_cyc;   // idle INPUT cycles before first press
        bit          poke;       // pulse start during SHOW_ON
        int          final_act;  // what happens in the following round
        logic [31:0] exp_value;
        logic        exp_lose;
        logic        exp_win;
    } vec_t;

    logic CLK;
    logic CPU_RESETN;

    simon_game_ctrl_if bus();

    simon_game_ctrl #(
        .TICKS_PER_STEP(T),
        .TIMEOUT_STEPS (S),
        .MAX_LEN       (M),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .CLK       (CLK),
        .CPU_RESETN(CPU_RESETN),
        .bus       (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          total = 0;
    int          bad   = 0;
    int          score = 0;
    logic [3:0]  hist[$];
    logic [31:0] exp_q[$];
    vec_t        vecs[6];

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bcd(input int s);
        return {24'd0, 4'(s / 10), 4'(s % 10)};
    endfunction

    // Pulse start from IDLE and check the start-of-game latencies.
    task automatic do_start();
        hist.delete();
        score = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_busy", 32'(bus.busy), 1);
        chk("start_value", bus.value, 0);
        chk("start_lose", 32'(bus.lose), 0);
        chk("start_win", 32'(bus.win), 0);
        chk("start_led", 32'(bus.led), 0);
        tick();
        chk("start_led2", 32'(bus.led), 0);
        tick();
        chk("first_led", 32'(bus.led != 4'd0), 1);
    endtask

    // Watch one round of len colours, then perform the action in INPUT.
    task automatic play_round(input int len, input int act, input int wait_cyc, input bit poke);
        int n;
        logic [3:0] c;
        n = 0;
        while (bus.led == 4'd0 && n < 40) begin
            tick();
            n++;
        end
        if (bus.led == 4'd0) begin
            chk("led_wait", 32'(bus.led), 1);
            return;
        end
        for (int i = 0; i < len; i++) begin
            c = bus.led;
            if (i < hist.size()) chk("seq_replay", 32'(c), 32'(hist[i]));
            else begin
                chk("new_onehot", 32'($onehot(c)), 1);
                hist.push_back(c);
            end
            for (int k = 1; k < T; k++) begin
                bus.start = (poke && i == 0 && k == 1);
                tick();
                chk("led_on", 32'(bus.led), 32'(c));
            end
            bus.start = 1'b0;
            for (int k = 0; k < T; k++) begin
                tick();
                chk("led_off", 32'(bus.led), 0);
            end
            if (i < len - 1) tick();
        end
        // Now in the first INPUT cycle; a press driven here is sampled next edge.
        case (act)
            A_OK: begin
                repeat (wait_cyc) tick();
                for (int i = 0; i < len; i++) begin
                    bus.btn = hist[i];
                    if (i == len - 1) begin
                        score++;
                        exp_q.push_back(bcd(score));
                    end
                    tick();
                    bus.btn = 4'd0;
                    if (i < len - 1) tick();
                end
                chk("score", bus.value, exp_q.pop_front());
            end
            A_WRONG, A_MULTI: begin
                bus.btn = (act == A_MULTI) ? 4'b0011 : {hist[0][2:0], hist[0][3]};
                tick();
                bus.btn = 4'd0;
                chk("lose_early", 32'(bus.lose), 0);
                chk("busy_hold", 32'(bus.busy), 1);
                tick();
                chk("lose_set", 32'(bus.lose), 1);
                chk("busy_drop", 32'(bus.busy), 0);
            end
            A_TIMEOUT: begin
                repeat (T * S) tick();
                chk("to_lose_early", 32'(bus.lose), 0);
                chk("to_busy_hold", 32'(bus.busy), 1);
                tick();
                chk("to_lose_set", 32'(bus.lose), 1);
                chk("to_busy_drop", 32'(bus.busy), 0);
            end
            default: ;
        endcase
    endtask

    task automatic run_game(input vec_t v);
        do_start();
        for (int r = 1; r <= v.rounds_ok; r++)
            play_round(r, A_OK, v.wait_cyc, v.poke);
        if (v.final_act != A_NONE)
            play_round(v.rounds_ok + 1, v.final_act, 0, 1'b0);
        else begin
            tick();
            chk("win_set", 32'(bus.win), 1);
            chk("win_busy", 32'(bus.busy), 0);
        end
        tick();
        chk("end_value", bus.value, v.exp_value);
        chk("end_lose", 32'(bus.lose), 32'(v.exp_lose));
        chk("end_win", 32'(bus.win), 32'(v.exp_win));
        chk("end_led", 32'(bus.led), 0);
        chk("end_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        int n;
        vecs[0] = '{1, 0,  1'b0, A_WRONG,   32'h01, 1'b1, 1'b0};
        vecs[1] = '{0, 0,  1'b0, A_TIMEOUT, 32'h00, 1'b1, 1'b0};
        vecs[2] = '{1, 11, 1'b0, A_TIMEOUT, 32'h01, 1'b1, 1'b0};
        vecs[3] = '{0, 0,  1'b0, A_MULTI,   32'h00, 1'b1, 1'b0};
        vecs[4] = '{2, 0,  1'b1, A_WRONG,   32'h02, 1'b1, 1'b0};
        vecs[5] = '{M, 0,  1'b0, A_NONE,    32'h04, 1'b0, 1'b1};

        CPU_RESETN = 1'b0;
        bus.start  = 1'b0;
        bus.btn    = 4'd0;
        repeat (2) tick();
        chk("rst_led", 32'(bus.led), 0);
        chk("rst_value", bus.value, 0);
        chk("rst_lose", 32'(bus.lose), 0);
        chk("rst_win", 32'(bus.win), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        CPU_RESETN = 1'b1;
        repeat (2) tick();

        foreach (vecs[i]) run_game(vecs[i]);

        // Reset during round-2 SHOW_ON takes effect without a clock edge.
        do_start();
        play_round(1, A_OK, 0, 1'b0);
        n = 0;
        while (bus.led == 4'd0 && n < 40) begin
            tick();
            n++;
        end
        chk("mid_led_on", 32'(bus.led != 4'd0), 1);
        #2 CPU_RESETN = 1'b0;
        #1;
        chk("mid_rst_led", 32'(bus.led), 0);
        chk("mid_rst_value", bus.value, 0);
        chk("mid_rst_lose", 32'(bus.lose), 0);
        chk("mid_rst_win", 32'(bus.win), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        tick();
        CPU_RESETN = 1'b1;
        repeat (2) tick();
        run_game(vecs[5]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/simon_game_ctrl.md
# simon_game_ctrl

Game sequencer for the Simon design on the Nexys A7. Grows a pseudo-random colour sequence one step per round, plays it on four LEDs, checks player button presses against it, and keeps the score. Drives the `value` and `lose` inputs of the seven-segment display driver, plus the four game LEDs.

## Interface

Parameters:
- `TICKS_PER_STEP`, default 50_000_000: CLK cycles per LED on-phase and per off-phase (0.5 s at 100 MHz).
- `TIMEOUT_STEPS`, default 10: input timeout, in units of `TICKS_PER_STEP`.
- `MAX_LEN`, default 32: sequence length that wins the game; range 1..32.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be non-zero.

Ports:
- `CLK`  in  1  system clock, 100 MHz.
- `CPU_RESETN`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  one-cycle pulse, debounced externally; begins a new game.
- `btn`  in  4  one-cycle press pulses, debounced externally; bit i is colour i.
- `led`  out  4  one-hot colour being shown; 0 when dark.
- `value`  out  32  score in BCD: [3:0] units, [7:4] tens, [31:8] zero.
- `lose`  out  1  high from a failed game until the next accepted `start`.
- `win`  out  1  high from a completed game until the next accepted `start`.
- `busy`  out  1  high in every state except IDLE.

## Operation

- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle in all states. New colour is `lfsr[1:0]`.
- Sequence memory: 32 × 2 bits. Counters: `len` (0..MAX_LEN), `idx`, and a step/timeout timer sized for `TICKS_PER_STEP*TIMEOUT_STEPS`.
- IDLE: `led`=0. `value`, `lose` and `win` hold their values. On `start`: clear `len`, score, `lose` and `win`, then go to ADD.
- ADD: `seq[len]`<=`lfsr[1:0]`, `len`<=`len`+1, `idx`<=0, then go to SHOW_ON.
- SHOW_ON: `led`=onehot(`seq[idx]`) for `TICKS_PER_STEP` cycles, then go to SHOW_OFF.
- SHOW_OFF: `led`=0 for `TICKS_PER_STEP` cycles.
  - If `idx`==`len`-1: `idx`<=0, clear the timer, go to INPUT.
  - Otherwise: `idx`++, go to SHOW_ON.
- INPUT: `led`=0. Any `btn`≠0 is a press.
  - Correct press: `btn`==onehot(`seq[idx]`).
  - Correct press with `idx`<`len`-1: `idx`++, clear the timer.
  - Correct press with `idx`==`len`-1: score+1 (BCD, units wrap 9→0 with carry into tens). Then go to WIN if `len`==MAX_LEN, else ADD.
  - Wrong press, including more than one bit set: go to LOSE.
  - Timer reaches `TICKS_PER_STEP*TIMEOUT_STEPS` with no press: go to LOSE.
- LOSE: `lose`<=1, go to IDLE.
- WIN: `win`<=1, go to IDLE.
- Score equals the number of completed rounds; it is never cleared by a loss.

## Timing

- Reset (async): state=IDLE, `led`=0, `value`=0, `lose`=0, `win`=0, `busy`=0, `len`=0, `lfsr`=`LFSR_SEED`. Reset mid-game abandons the game immediately.
- All outputs are registered.
- `start` in IDLE at edge n: `busy`=1 after edge n; ADD for one cycle; first `led` on after edge n+2.
- Each LED on-phase and off-phase is exactly `TICKS_PER_STEP` cycles.
- Press accepted at edge n: the score update is visible after edge n. `lose` or `win` is visible after edge n+1, the same edge that returns `busy` to 0.
- `start` outside IDLE is ignored. `btn` outside INPUT is ignored.
- Press and timeout in the same cycle: the press wins.
- `btn`=0 is never a press.

## Test plan

Bench parameters: `TICKS_PER_STEP`=4, `TIMEOUT_STEPS`=3, `MAX_LEN`=4.

- Reset: pulse `CPU_RESETN` low during SHOW_ON → `led`=0, `value`=0, `lose`=0, `win`=0, `busy`=0 without waiting for CLK. A later `start` runs a full game normally.
- Round 1: `start`, record the one-hot shown for 4 cycles (off 4 cycles after), echo it on `btn` → `value`=32'h01. Round 2 shows 2 colours, the first equal to the round-1 colour.
- Wrong press: in round 2, send an incorrect one-hot → `lose`=1 and `busy`=0 two edges later, `value` stays 32'h01. A second `start` clears `lose` and `value`.
- Timeout: enter INPUT and send no press → `lose`=1 after 12 cycles. A press in the 12th cycle is accepted instead of timing out.
- Win: echo 4 rounds correctly → `value`=32'h04, `win`=1, `lose`=0, `led`=0, `busy`=0.
- Illegal stimulus: `btn`=4'b0011 in INPUT → `lose`=1. `start` pulsed during SHOW_ON → no effect on sequence, `len` or score.
